// File: rtl/highlight_suppress_h5.sv
// Highlight suppressor: luma-thresholded 5-tap horizontal Gaussian
// conditioning on a per_/post_ RGB frame bus, with per-frame highlight stats.
module highlight_suppress_h5 #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_hsync,
  input  logic                  per_frame_href,
  input  logic [DATA_WIDTH-1:0] per_img_red,
  input  logic [DATA_WIDTH-1:0] per_img_green,
  input  logic [DATA_WIDTH-1:0] per_img_blue,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_threshold,
  output logic                  post_frame_vsync,
  output logic                  post_frame_hsync,
  output logic                  post_frame_href,
  output logic [DATA_WIDTH-1:0] post_img_red,
  output logic [DATA_WIDTH-1:0] post_img_green,
  output logic [DATA_WIDTH-1:0] post_img_blue,
  output logic [CNT_WIDTH-1:0]  stat_hl_count,
  output logic                  stat_valid,
  output logic                  stat_overrun
);

  localparam int XW = $clog2(LINE_WIDTH + 1);
  localparam int BW = DATA_WIDTH + 4;
  localparam int YW = DATA_WIDTH + 8;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } pix_t;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t state, state_next;

  pix_t sh [4];
  pix_t pin, nx, cen, blr, mixed;

  logic [XW-1:0] x;
  logic armed, fl_cnt, vs_q;
  logic [2:0] vs_dl, hs_dl;
  logic [1:0] mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic sync, vs_rise;
  logic start, cont, abort, drop, emit;
  logic [YW-1:0] yy;
  logic [DATA_WIDTH-1:0] y;
  logic hl;

  function automatic logic [DATA_WIDTH-1:0] blur5(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] d,
    input logic [DATA_WIDTH-1:0] e
  );
    logic [BW-1:0] s;
    s = BW'(a) + (BW'(b) << 2) + (BW'(c) << 2) + (BW'(c) << 1)
      + (BW'(d) << 2) + BW'(e) + BW'(8);
    return DATA_WIDTH'(s >> 4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mix(
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] b,
    input logic [1:0]            m,
    input logic                  h
  );
    logic [DATA_WIDTH:0] s;
    s = {1'b0, c} + {1'b0, b} + (DATA_WIDTH+1)'(1);
    case (m)
      2'd0:    return c;
      2'd1:    return h ? b : c;
      2'd2:    return h ? DATA_WIDTH'(s >> 1) : c;
      default: return h ? '1 : '0;
    endcase
  endfunction

  assign pin = {per_img_red, per_img_green, per_img_blue};
  assign sync = per_frame_hsync | per_frame_vsync;
  assign vs_rise = per_frame_vsync & ~vs_q;

  // Window: four stored taps plus the incoming (or replicated last) pixel
  assign nx  = (state == FLUSH) ? sh[3] : pin;
  assign cen = sh[2];

  // Blur, luma and mode-conditioned output for the centre pixel
  always_comb begin
    blr.r = blur5(sh[0].r, sh[1].r, sh[2].r, sh[3].r, nx.r);
    blr.g = blur5(sh[0].g, sh[1].g, sh[2].g, sh[3].g, nx.g);
    blr.b = blur5(sh[0].b, sh[1].b, sh[2].b, sh[3].b, nx.b);
    yy = YW'(77) * YW'(cen.r) + YW'(150) * YW'(cen.g)
       + YW'(29) * YW'(cen.b);
    y  = DATA_WIDTH'(yy >> 8);
    hl = y > thr_q;
    mixed.r = mix(cen.r, blr.r, mode_q, hl);
    mixed.g = mix(cen.g, blr.g, mode_q, hl);
    mixed.b = mix(cen.b, blr.b, mode_q, hl);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL, RUN: begin
        if (start)
          state_next = FILL;
        else if (sync)
          state_next = IDLE;
        else if (cont) begin
          if (x == X_LAST)     state_next = FLUSH;
          else if (x >= X_TWO) state_next = RUN;
        end
      end
      FLUSH: if (fl_cnt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: line start, continue, abort, drop and emit strobes
  always_comb begin
    start = 1'b0;
    cont  = 1'b0;
    abort = 1'b0;
    drop  = 1'b0;
    emit  = 1'b0;
    case (state)
      IDLE: start = per_frame_href & (sync | armed);
      FILL, RUN: begin
        abort = sync;
        start = per_frame_href & sync;
        cont  = per_frame_href & ~sync;
        emit  = cont & (x >= X_TWO);
      end
      FLUSH: begin
        drop = per_frame_href;
        emit = 1'b1;
      end
      default: ;
    endcase
  end

  // Column position, flush phase and line-start arming
  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      fl_cnt <= 1'b0;
      armed  <= 1'b0;
    end else begin
      if (start)     x <= XW'(1);
      else if (cont) x <= x + XW'(1);
      else if (sync) x <= '0;
      fl_cnt <= (state == FLUSH) ? ~fl_cnt : 1'b0;
      if (start)     armed <= 1'b0;
      else if (sync) armed <= 1'b1;
    end
  end

  // Tap shift register; first pixel of a line replicates into every tap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sh[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < 4; i++) sh[i] <= pin;
    end else if (cont || state == FLUSH) begin
      sh[0] <= sh[1];
      sh[1] <= sh[2];
      sh[2] <= sh[3];
      sh[3] <= nx;
    end
  end

  // Sync delay line and frame config latch
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_dl  <= '0;
      hs_dl  <= '0;
      vs_q   <= 1'b0;
      mode_q <= 2'd0;
      thr_q  <= '1;
    end else begin
      vs_dl <= {vs_dl[1:0], per_frame_vsync};
      hs_dl <= {hs_dl[1:0], per_frame_hsync};
      vs_q  <= per_frame_vsync;
      if (vs_rise) begin
        mode_q <= cfg_mode;
        thr_q  <= cfg_threshold;
      end
    end
  end

  assign post_frame_vsync = vs_dl[2];
  assign post_frame_hsync = hs_dl[2];

  // Registered pixel output
  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_href <= 1'b0;
      post_img_red    <= '0;
      post_img_green  <= '0;
      post_img_blue   <= '0;
    end else begin
      post_frame_href <= emit;
      post_img_red    <= emit ? mixed.r : '0;
      post_img_green  <= emit ? mixed.g : '0;
      post_img_blue   <= emit ? mixed.b : '0;
    end
  end

  // Highlight counter, frame statistic and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      stat_hl_count <= '0;
      stat_valid    <= 1'b0;
      stat_overrun  <= 1'b0;
    end else begin
      stat_valid <= vs_rise;
      if (vs_rise) begin
        stat_hl_count <= cnt;
        cnt <= (emit && hl) ? CNT_WIDTH'(1) : '0;
      end else if (emit && hl && cnt != '1) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (abort || drop) stat_overrun <= 1'b1;
      else if (vs_rise)  stat_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_highlight_suppress_h5.sv
// Directed bench for highlight_suppress_h5 with an 8-pixel line,
// hand-computed pixel values, latency, statistics and overrun cases.
module tb_highlight_suppress_h5;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync, hsync, href;
  logic [7:0] red, green, blue;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_threshold;
  logic       post_frame_vsync, post_frame_hsync, post_frame_href;
  logic [7:0] post_img_red, post_img_green, post_img_blue;
  logic [19:0] stat_hl_count;
  logic       stat_valid, stat_overrun;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] qr[$], qg[$], qb[$];
  longint qt[$];
  int sv_cnt = 0;
  longint sv_val = -1;
  longint t2, t5, tv;

  logic [7:0] l_spot [8] = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] l_edge [8] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] l_zero [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  highlight_suppress_h5 #(
    .DATA_WIDTH(8),
    .LINE_WIDTH(8),
    .CNT_WIDTH(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .per_frame_vsync(vsync),
    .per_frame_hsync(hsync),
    .per_frame_href(href),
    .per_img_red(red),
    .per_img_green(green),
    .per_img_blue(blue),
    .cfg_mode(cfg_mode),
    .cfg_threshold(cfg_threshold),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_hsync(post_frame_hsync),
    .post_frame_href(post_frame_href),
    .post_img_red(post_img_red),
    .post_img_green(post_img_green),
    .post_img_blue(post_img_blue),
    .stat_hl_count(stat_hl_count),
    .stat_valid(stat_valid),
    .stat_overrun(stat_overrun)
  );

  always #5 clk = ~clk;

  // Capture emitted pixels and statistic pulses away from the active edge
  always @(negedge clk) begin
    if (post_frame_href) begin
      qr.push_back(post_img_red);
      qg.push_back(post_img_green);
      qb.push_back(post_img_blue);
      qt.push_back($time);
    end
    if (stat_valid) begin
      sv_cnt++;
      sv_val = longint'(stat_hl_count);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint pr(input int i);
    return (i < qr.size()) ? longint'(qr[i]) : -1;
  endfunction

  function automatic longint pg(input int i);
    return (i < qg.size()) ? longint'(qg[i]) : -1;
  endfunction

  function automatic longint pb(input int i);
    return (i < qb.size()) ? longint'(qb[i]) : -1;
  endfunction

  function automatic longint pt(input int i);
    return (i < qt.size()) ? qt[i] : -1;
  endfunction

  task automatic clear_q();
    qr.delete();
    qg.delete();
    qb.delete();
    qt.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vsync = 1'b0;
      hsync = 1'b0;
      href  = 1'b0;
    end
  endtask

  task automatic send_line(input logic [7:0] v [8], input int n, input bit extra);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hsync = (i == 0);
      href  = 1'b1;
      red   = v[i];
      green = v[i];
      blue  = v[i];
      if (i == 2) t2 = $time;
      if (i == 5) t5 = $time;
    end
    @(negedge clk);
    hsync = 1'b0;
    href  = extra;
    @(negedge clk);
    href  = 1'b0;
  endtask

  task automatic new_frame(input logic [1:0] m);
    cfg_mode = m;
    @(negedge clk);
    vsync = 1'b1;
    hsync = 1'b0;
    href  = 1'b0;
    @(negedge clk);
    vsync = 1'b0;
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b0;
    hsync = 1'b0;
    href = 1'b0;
    red = 8'd0;
    green = 8'd0;
    blue = 8'd0;
    cfg_mode = 2'd0;
    cfg_threshold = 8'd200;
    repeat (3) @(negedge clk);
    check("rst_href", post_frame_href, 0);
    check("rst_red", post_img_red, 0);
    check("rst_stat", stat_hl_count, 0);
    check("rst_valid", stat_valid, 0);
    check("rst_ovr", stat_overrun, 0);
    check("rst_vsync", post_frame_vsync, 0);
    rst = 1'b0;
    idle(2);

    // Mode 1 on a single bright spot, plus latency
    new_frame(2'd1);
    clear_q();
    send_line(l_spot, 8, 1'b0);
    idle(5);
    check("t1_count", qr.size(), 8);
    check("t1_p0", pr(0), 0);
    check("t1_p2", pr(2), 0);
    check("t1_p3r", pr(3), 96);
    check("t1_p3g", pg(3), 96);
    check("t1_p3b", pb(3), 96);
    check("t1_p4", pr(4), 0);
    check("t1_p7", pr(7), 0);
    check("t1_lat0", pt(0), t2 + 10);
    check("t1_lat3", pt(3), t5 + 10);

    // Mode 2 blend, then mode 3 mask
    new_frame(2'd2);
    clear_q();
    send_line(l_spot, 8, 1'b0);
    idle(5);
    check("t2_blend", pr(3), 176);
    check("t2_blend_p2", pr(2), 0);
    new_frame(2'd3);
    clear_q();
    send_line(l_spot, 8, 1'b0);
    idle(5);
    check("t2_mask_p3", pr(3), 255);
    check("t2_mask_p3b", pb(3), 255);
    check("t2_mask_p0", pr(0), 0);
    check("t2_mask_p4", pr(4), 0);

    // Left edge replication
    new_frame(2'd1);
    clear_q();
    send_line(l_edge, 8, 1'b0);
    idle(5);
    check("t3_count", qr.size(), 8);
    check("t3_p0", pr(0), 175);
    check("t3_p1", pr(1), 0);
    check("t3_p7", pr(7), 0);

    // Five-line frame with two highlights; mid-frame mode change deferred
    new_frame(2'd1);
    sv_cnt = 0;
    send_line(l_spot, 8, 1'b0);
    idle(2);
    send_line(l_zero, 8, 1'b0);
    idle(2);
    cfg_mode = 2'd3;
    clear_q();
    send_line(l_spot, 8, 1'b0);
    idle(2);
    check("t4_midcfg", pr(3), 96);
    send_line(l_zero, 8, 1'b0);
    idle(2);
    send_line(l_zero, 8, 1'b0);
    idle(2);
    check("t4_nopulse", sv_cnt, 0);
    new_frame(2'd3);
    check("t4_pulse", sv_cnt, 1);
    check("t4_stat", sv_val, 2);
    clear_q();
    send_line(l_spot, 8, 1'b0);
    idle(5);
    check("t4_newmode", pr(3), 255);
    check("t4_newmode_p0", pr(0), 0);

    // Aborted line, then href during flush
    new_frame(2'd1);
    check("t5_ovr_clr", stat_overrun, 0);
    clear_q();
    send_line(l_spot, 4, 1'b0);
    @(negedge clk);
    hsync = 1'b1;
    idle(5);
    check("t5_abort_ovr", stat_overrun, 1);
    check("t5_abort_cnt", qr.size(), 2);
    new_frame(2'd1);
    check("t5_ovr_clr2", stat_overrun, 0);
    clear_q();
    send_line(l_spot, 8, 1'b1);
    idle(5);
    check("t5_drop_ovr", stat_overrun, 1);
    check("t5_drop_cnt", qr.size(), 8);
    check("t5_drop_p3", pr(3), 96);

    // Reset mid-line, then recovery
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hsync = (i == 0);
      href  = 1'b1;
      red   = l_spot[i];
      green = l_spot[i];
      blue  = l_spot[i];
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    check("t6_rst_href", post_frame_href, 0);
    check("t6_rst_red", post_img_red, 0);
    check("t6_rst_ovr", stat_overrun, 0);
    check("t6_rst_stat", stat_hl_count, 0);
    rst = 1'b0;
    hsync = 1'b0;
    clear_q();
    for (int i = 5; i < 8; i++) begin
      red   = l_spot[i];
      green = l_spot[i];
      blue  = l_spot[i];
      @(negedge clk);
    end
    idle(5);
    check("t6_nolead", qr.size(), 0);
    cfg_mode = 2'd1;
    @(negedge clk);
    vsync = 1'b1;
    tv = $time;
    @(negedge clk);
    vsync = 1'b0;
    check("t6_vs_d1", post_frame_vsync, 0);
    @(negedge clk);
    check("t6_vs_d2", post_frame_vsync, 0);
    @(negedge clk);
    check("t6_vs_d3", post_frame_vsync, 1);
    check("t6_vs_time", $time - tv, 30);
    @(negedge clk);
    check("t6_vs_d4", post_frame_vsync, 0);
    idle(2);
    clear_q();
    send_line(l_spot, 8, 1'b0);
    idle(5);
    check("t6_count", qr.size(), 8);
    check("t6_p3", pr(3), 96);
    check("t6_p2", pr(2), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
